// File: rtl/uart_hex_pkg.sv
// Shared ASCII constants, default digit count and enums for the UART hex line editor.
package uart_hex_pkg;

    localparam int NDIG_DEF = 8;

    localparam logic [7:0] A_BS  = 8'h08;
    localparam logic [7:0] A_DEL = 8'h7F;
    localparam logic [7:0] A_CR  = 8'h0D;
    localparam logic [7:0] A_LF  = 8'h0A;
    localparam logic [7:0] A_ESC = 8'h1B;
    localparam logic [7:0] A_BEL = 8'h07;
    localparam logic [7:0] A_SP  = 8'h20;

    typedef enum logic {S_IDLE, S_TX} state_e;

    typedef enum logic [2:0] {C_OTHER, C_HEX, C_BS, C_CR, C_ESC} cls_e;

endpackage

// File: rtl/ascii_hex_decode.sv
// Classifies a received ASCII byte and extracts its hex nibble.
// Purely combinational; no backpressure.
module ascii_hex_decode
    import uart_hex_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [2:0] o_cls,
    output logic [3:0] o_nib
);

    always_comb begin
        o_cls = C_OTHER;
        o_nib = 4'h0;
        if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
            o_cls = C_HEX;
            o_nib = i_byte[3:0];
        end else if ((i_byte >= 8'h41 && i_byte <= 8'h46) ||
                     (i_byte >= 8'h61 && i_byte <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them to 10
            o_cls = C_HEX;
            o_nib = i_byte[3:0] + 4'd9;
        end else if (i_byte == A_BS || i_byte == A_DEL) begin
            o_cls = C_BS;
        end else if (i_byte == A_CR) begin
            o_cls = C_CR;
        end else if (i_byte == A_ESC) begin
            o_cls = C_ESC;
        end
    end

endmodule

// File: rtl/uart_hex_entry.sv
// Hex line editor: collects digits, commits on CR, echoes keystrokes to the UART TX.
// Edit/commit registers update on the rx edge; echo valid from the next cycle.
// Echo held under tx backpressure; rx bytes arriving while echoing are dropped.
module uart_hex_entry
    import uart_hex_pkg::*;
#(
    parameter int NDIG = NDIG_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic [4*NDIG-1:0] o_bcd8d,
    output logic [4*NDIG-1:0] o_edit,
    output logic [3:0]        o_cnt,
    output logic              o_commit,
    output logic              o_drop
);

    localparam int         W      = 4 * NDIG;
    localparam logic [3:0] NDIG_C = 4'(NDIG);

    state_e              state_q, state_d;
    logic [W-1:0]        edit_q, edit_d;
    logic [W-1:0]        bcd_q, bcd_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                commit_q, commit_d;
    logic                drop_q, drop_d;
    logic [2:0][7:0]     seq_q, seq_d;
    logic [1:0]          len_q, len_d;
    logic [1:0]          idx_q, idx_d;
    logic                echo_go;

    logic [2:0] cls_w;
    logic [3:0] nib_w;

    ascii_hex_decode u_dec (
        .i_byte (i_rx_data),
        .o_cls  (cls_w),
        .o_nib  (nib_w)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            edit_q   <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            commit_q <= 1'b0;
            drop_q   <= 1'b0;
            seq_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            edit_q   <= edit_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            commit_q <= commit_d;
            drop_q   <= drop_d;
            seq_q    <= seq_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        edit_d   = edit_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        commit_d = 1'b0;
        drop_d   = 1'b0;
        seq_d    = seq_q;
        len_d    = len_q;
        idx_d    = idx_q;
        echo_go  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_rx_valid) begin
                    case (cls_w)
                        C_HEX: begin
                            echo_go = 1'b1;
                            len_d   = 2'd1;
                            if (cnt_q < NDIG_C) begin
                                edit_d   = {edit_q[W-5:0], nib_w};
                                cnt_d    = cnt_q + 4'd1;
                                seq_d[0] = i_rx_data;
                            end else begin
                                seq_d[0] = A_BEL;
                            end
                        end
                        C_BS: begin
                            if (cnt_q != 4'd0) begin
                                echo_go  = 1'b1;
                                edit_d   = edit_q >> 4;
                                cnt_d    = cnt_q - 4'd1;
                                seq_d[0] = A_BS;
                                seq_d[1] = A_SP;
                                seq_d[2] = A_BS;
                                len_d    = 2'd3;
                            end
                        end
                        C_CR, C_ESC: begin
                            if (cls_w == C_CR) begin
                                bcd_d    = edit_q;
                                commit_d = 1'b1;
                            end
                            echo_go  = 1'b1;
                            edit_d   = '0;
                            cnt_d    = '0;
                            seq_d[0] = A_CR;
                            seq_d[1] = A_LF;
                            len_d    = 2'd2;
                        end
                        default: ;
                    endcase
                    if (echo_go) begin
                        state_d = S_TX;
                        idx_d   = 2'd0;
                    end
                end
            end
            S_TX: begin
                drop_d = i_rx_valid;
                if (i_tx_ready) begin
                    if (idx_q == len_q - 2'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_tx_valid = (state_q == S_TX);
    assign o_tx_data  = seq_q[idx_q];
    assign o_bcd8d    = bcd_q;
    assign o_edit     = edit_q;
    assign o_cnt      = cnt_q;
    assign o_commit   = commit_q;
    assign o_drop     = drop_q;

endmodule
